// File: rtl/ntt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_ctrl
//  Description : In-place NTT / inverse NTT address sequencer for a
//                single-cycle butterfly over a 2^LOGN word coefficient memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module ntt_ctrl #(
    parameter int LOGN = 8,
    parameter int AW   = LOGN
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    start_i,
    input  logic                    mode_i,
    input  logic                    mul_sel_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [$clog2(LOGN)-1:0] stage_o,
    output logic                    rd_en_o,
    output logic [AW-1:0]           rd_addr_a_o,
    output logic [AW-1:0]           rd_addr_b_o,
    output logic [AW-1:0]           tw_addr_o,
    output logic                    wr_en_o,
    output logic [AW-1:0]           wr_addr_a_o,
    output logic [AW-1:0]           wr_addr_b_o,
    output logic                    sel_butterfly_o,
    output logic                    sel_mul_o
);

    localparam int c_sw = $clog2(LOGN);
    localparam int c_iw = LOGN - 1;

    localparam logic [c_sw:0]   c_top        = (c_sw + 1)'(LOGN - 1);
    localparam logic [c_sw-1:0] c_last_stage = c_sw'(LOGN - 1);
    localparam logic [c_iw-1:0] c_last_i     = {c_iw{1'b1}};
    localparam logic [AW-1:0]   c_one        = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]   c_nm1        = AW'((64'd1 << LOGN) - 64'd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t            r_state;
    logic [c_sw-1:0]   r_stage;
    logic [c_iw-1:0]   r_i;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_en;
    logic [AW-1:0]     r_rd_a;
    logic [AW-1:0]     r_rd_b;
    logic [AW-1:0]     r_tw;
    logic              r_wr_en;
    logic [AW-1:0]     r_wr_a;
    logic [AW-1:0]     r_wr_b;
    logic              r_sel_bfly;
    logic              r_sel_mul;

    // Coordinates of the read that will be presented after the next edge
    logic [c_sw-1:0]   w_gen_stage;
    logic [c_iw-1:0]   w_gen_i;
    logic              w_gen_mode;

    logic [c_sw:0]     w_l;
    logic [AW-1:0]     w_i_ext;
    logic [AW-1:0]     w_len;
    logic [AW-1:0]     w_blk;
    logic [AW-1:0]     w_a;
    logic [AW-1:0]     w_b;
    logic [AW-1:0]     w_tw;

    always_comb begin
        w_gen_mode  = r_sel_bfly;
        w_gen_stage = r_stage;
        w_gen_i     = r_i + 1'b1;
        if ((r_state == S_IDLE) || (r_state == S_FIN)) begin
            w_gen_mode  = mode_i;
            w_gen_stage = '0;
            w_gen_i     = '0;
        end else if (r_state == S_GAP) begin
            w_gen_stage = (r_stage == c_last_stage) ? r_stage : r_stage + 1'b1;
            w_gen_i     = '0;
        end
    end

    // Forward halves the span each stage, inverse doubles it
    always_comb begin
        w_l     = w_gen_mode ? {1'b0, w_gen_stage} : (c_top - {1'b0, w_gen_stage});
        w_i_ext = {{(AW-c_iw){1'b0}}, w_gen_i};
        w_len   = c_one << w_l;
        w_blk   = w_i_ext >> w_l;
        w_a     = (w_blk << (w_l + 1'b1)) | (w_i_ext & (w_len - c_one));
        w_b     = w_a | w_len;
        // Inverse index 2^(LOGN-s)-1-blk: blk only occupies bits under the mask
        w_tw    = w_gen_mode ? ((c_nm1 >> w_gen_stage) ^ w_blk)
                             : ((c_one << w_gen_stage) | w_blk);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state    <= S_IDLE;
            r_stage    <= '0;
            r_i        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rd_a     <= '0;
            r_rd_b     <= '0;
            r_tw       <= '0;
            r_wr_en    <= 1'b0;
            r_wr_a     <= '0;
            r_wr_b     <= '0;
            r_sel_bfly <= 1'b0;
            r_sel_mul  <= 1'b0;
        end else begin
            r_wr_en <= r_rd_en;
            r_wr_a  <= r_rd_a;
            r_wr_b  <= r_rd_b;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE, S_FIN: begin
                    if (start_i) begin
                        r_state    <= S_RUN;
                        r_busy     <= 1'b1;
                        r_stage    <= w_gen_stage;
                        r_i        <= w_gen_i;
                        r_sel_bfly <= mode_i;
                        r_sel_mul  <= mul_sel_i;
                        r_rd_en    <= 1'b1;
                        r_rd_a     <= w_a;
                        r_rd_b     <= w_b;
                        r_tw       <= w_tw;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (r_i == c_last_i) begin
                        r_state <= S_GAP;
                        r_rd_en <= 1'b0;
                    end else begin
                        r_i    <= w_gen_i;
                        r_rd_a <= w_a;
                        r_rd_b <= w_b;
                        r_tw   <= w_tw;
                    end
                end
                S_GAP: begin
                    if (r_stage == c_last_stage) begin
                        r_state <= S_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                        r_stage <= w_gen_stage;
                        r_i     <= w_gen_i;
                        r_rd_en <= 1'b1;
                        r_rd_a  <= w_a;
                        r_rd_b  <= w_b;
                        r_tw    <= w_tw;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign stage_o         = r_stage;
    assign rd_en_o         = r_rd_en;
    assign rd_addr_a_o     = r_rd_a;
    assign rd_addr_b_o     = r_rd_b;
    assign tw_addr_o       = r_tw;
    assign wr_en_o         = r_wr_en;
    assign wr_addr_a_o     = r_wr_a;
    assign wr_addr_b_o     = r_wr_b;
    assign sel_butterfly_o = r_sel_bfly;
    assign sel_mul_o       = r_sel_mul;

endmodule
`default_nettype wire

// File: tb/tb_ntt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ntt_ctrl
//  Description : Directed bench for ntt_ctrl (LOGN=3 sequencing, LOGN=8 NTT).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_ctrl;

    localparam int c_q = 7681;
    localparam int c_n = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       r_rstn = 1'b0;
    logic       r_start = 1'b0, r_mode = 1'b0, r_mul = 1'b0;
    logic       r8_start = 1'b0, r8_mode = 1'b0;

    logic       w_busy, w_done, w_rd_en, w_wr_en, w_sel_bf, w_sel_mul;
    logic [1:0] w_stage;
    logic [2:0] w_rd_a, w_rd_b, w_tw, w_wr_a, w_wr_b;

    logic       w8_busy, w8_done, w8_rd_en, w8_wr_en, w8_sel_bf, w8_sel_mul;
    logic [2:0] w8_stage;
    logic [7:0] w8_rd_a, w8_rd_b, w8_tw, w8_wr_a, w8_wr_b;

    ntt_ctrl #(.LOGN(3), .AW(3)) u_dut3 (
        .clk_i(clk), .rstn_i(r_rstn), .start_i(r_start), .mode_i(r_mode),
        .mul_sel_i(r_mul), .busy_o(w_busy), .done_o(w_done), .stage_o(w_stage),
        .rd_en_o(w_rd_en), .rd_addr_a_o(w_rd_a), .rd_addr_b_o(w_rd_b),
        .tw_addr_o(w_tw), .wr_en_o(w_wr_en), .wr_addr_a_o(w_wr_a),
        .wr_addr_b_o(w_wr_b), .sel_butterfly_o(w_sel_bf), .sel_mul_o(w_sel_mul)
    );

    ntt_ctrl #(.LOGN(8), .AW(8)) u_dut8 (
        .clk_i(clk), .rstn_i(r_rstn), .start_i(r8_start), .mode_i(r8_mode),
        .mul_sel_i(1'b0), .busy_o(w8_busy), .done_o(w8_done), .stage_o(w8_stage),
        .rd_en_o(w8_rd_en), .rd_addr_a_o(w8_rd_a), .rd_addr_b_o(w8_rd_b),
        .tw_addr_o(w8_tw), .wr_en_o(w8_wr_en), .wr_addr_a_o(w8_wr_a),
        .wr_addr_b_o(w8_wr_b), .sel_butterfly_o(w8_sel_bf), .sel_mul_o(w8_sel_mul)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hand-derived LOGN=3 read sequences, 4 butterflies per stage
    int fwd_a[12] = '{0,1,2,3, 0,1,4,5, 0,2,4,6};
    int fwd_b[12] = '{4,5,6,7, 2,3,6,7, 1,3,5,7};
    int fwd_t[12] = '{1,1,1,1, 2,2,3,3, 4,5,6,7};
    int inv_a[12] = '{0,2,4,6, 0,1,4,5, 0,1,2,3};
    int inv_b[12] = '{1,3,5,7, 2,3,6,7, 4,5,6,7};
    int inv_t[12] = '{7,6,5,4, 3,3,2,2, 1,1,1,1};

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Entered in cycle 0 (start high); checks cycles 1..16
    task automatic run3(input logic m, input int poke, input bit chain);
        int  ea, eb, et, pa, pb, k;
        bit  rd, prd, nm, ov;
        nm = ~m;
        r_mode = m; r_mul = nm; r_start = 1'b1;
        prd = 1'b0; pa = 0; pb = 0; ea = 0; eb = 0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            r_start = (c == poke) || (chain && c == 16);
            r_mode  = (c == poke) ? nm : m;
            r_mul   = (c == poke) ? m : nm;
            rd = (c <= 14) && ((c % 5) != 0);
            check("busy", w_busy, (c <= 15));
            check("done", w_done, (c == 16));
            check("rd_en", w_rd_en, rd);
            check("wr_en", w_wr_en, prd);
            if (rd) begin
                k  = (c - 1) - (c - 1) / 5;
                ea = m ? inv_a[k] : fwd_a[k];
                eb = m ? inv_b[k] : fwd_b[k];
                et = m ? inv_t[k] : fwd_t[k];
                check("rd_addr_a", w_rd_a, ea);
                check("rd_addr_b", w_rd_b, eb);
                check("tw_addr", w_tw, et);
                check("stage", w_stage, (c - 1) / 5);
            end
            if (prd) begin
                check("wr_addr_a", w_wr_a, pa);
                check("wr_addr_b", w_wr_b, pb);
            end
            check("sel_butterfly", w_sel_bf, m);
            check("sel_mul", w_sel_mul, nm);
            ov = w_rd_en && w_wr_en && (w_rd_a == w_wr_a || w_rd_a == w_wr_b ||
                                        w_rd_b == w_wr_a || w_rd_b == w_wr_b);
            check("rw_overlap", ov, 1'b0);
            prd = rd; pa = ea; pb = eb;
        end
    endtask

    task automatic reset_mid_run();
        r_mode = 1'b1; r_mul = 1'b1; r_start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            r_start = 1'b0;
        end
        check("pre_rst_rd_en", w_rd_en, 1'b1);
        check("pre_rst_rd_b", w_rd_b, 2);
        check("pre_rst_tw", w_tw, 3);
        check("pre_rst_stage", w_stage, 1);
        r_rstn = 1'b0;
        @(posedge clk); #1;
        check("rst_busy", w_busy, 0);
        check("rst_done", w_done, 0);
        check("rst_rd_en", w_rd_en, 0);
        check("rst_wr_en", w_wr_en, 0);
        check("rst_rd_b", w_rd_b, 0);
        check("rst_tw", w_tw, 0);
        check("rst_wr_b", w_wr_b, 0);
        check("rst_stage", w_stage, 0);
        check("rst_sel_bf", w_sel_bf, 0);
        check("rst_sel_mul", w_sel_mul, 0);
        r_rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("post_rst_wr_en", w_wr_en, 0);
            check("post_rst_rd_en", w_rd_en, 0);
        end
    endtask

    // ---------------- LOGN=8 memory / butterfly model ----------------
    int x_in[c_n];
    int gold[c_n];
    int mem[c_n];
    int twr[c_n];

    function automatic int mulmod(input int a, input int b);
        return int'((longint'(a) * longint'(b)) % longint'(c_q));
    endfunction

    function automatic int powmod(input int b, input int e);
        int r, p, k;
        r = 1; p = b; k = e;
        while (k > 0) begin
            if (k % 2 == 1) r = mulmod(r, p);
            p = mulmod(p, p);
            k = k / 2;
        end
        return r;
    endfunction

    function automatic int brv8(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 8; k++) if (((v >> k) & 1) == 1) r = r | (1 << (7 - k));
        return r;
    endfunction

    task automatic run8(input logic m, output int dcyc);
        int ca, cb, cw, c, t;
        ca = 0; cb = 0; cw = 0; c = 0; dcyc = -1;
        r8_mode = m; r8_start = 1'b1;
        while (c < 1200 && dcyc < 0) begin
            @(posedge clk); #1;
            c++;
            r8_start = 1'b0;
            if (w8_wr_en) begin
                if (!w8_sel_bf) begin
                    t = mulmod(cw, cb);
                    mem[w8_wr_a] = (ca + t) % c_q;
                    mem[w8_wr_b] = (ca - t + c_q) % c_q;
                end else begin
                    mem[w8_wr_a] = (ca + cb) % c_q;
                    mem[w8_wr_b] = mulmod((cb - ca + c_q) % c_q, cw);
                end
            end
            if (w8_rd_en) begin
                ca = mem[w8_rd_a];
                cb = mem[w8_rd_b];
                cw = twr[w8_tw];
            end
            if (w8_done) dcyc = c;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gen, psi, r, p, s, nbad, dcyc, ninv;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", w_busy, 0);
        check("reset_done", w_done, 0);
        check("reset_rd_en", w_rd_en, 0);
        check("reset_wr_en", w_wr_en, 0);
        check("reset_tw", w_tw, 0);
        check("reset_sel_mul", w_sel_mul, 0);
        check("reset8_busy", w8_busy, 0);
        r_rstn = 1'b1;
        idle(2);

        run3(1'b0, 0, 1'b0);
        idle(2);
        run3(1'b1, 0, 1'b0);
        idle(2);
        run3(1'b0, 7, 1'b1);
        run3(1'b1, 0, 1'b0);
        idle(2);
        reset_mid_run();
        run3(1'b0, 0, 1'b0);
        idle(2);

        // q-1 = 2^9*3*5; psi = g^15 is a primitive 512th root of unity
        gen = 2;
        for (int g = 2; g < c_q; g++) begin
            if (powmod(g, 3840) != 1 && powmod(g, 2560) != 1 && powmod(g, 1536) != 1) begin
                gen = g;
                break;
            end
        end
        psi = powmod(gen, 15);
        for (int k = 0; k < c_n; k++) begin
            twr[k]  = powmod(psi, brv8(k));
            x_in[k] = (k * 1237 + 45) % c_q;
            mem[k]  = x_in[k];
        end
        // Golden: output j is the input polynomial evaluated at psi^(2*brv(j)+1)
        for (int j = 0; j < c_n; j++) begin
            r = powmod(psi, 2 * brv8(j) + 1);
            p = 1; s = 0;
            for (int i = 0; i < c_n; i++) begin
                s = (s + mulmod(x_in[i], p)) % c_q;
                p = mulmod(p, r);
            end
            gold[j] = s;
        end

        run8(1'b0, dcyc);
        check("fwd_done_cycle", dcyc, 1033);
        nbad = 0;
        for (int j = 0; j < c_n; j++) if (mem[j] != gold[j]) nbad++;
        check("fwd_mem_bad_words", nbad, 0);
        check("fwd_mem_word5", mem[5], gold[5]);
        idle(3);

        run8(1'b1, dcyc);
        check("inv_done_cycle", dcyc, 1033);
        ninv = powmod(c_n, c_q - 2);
        nbad = 0;
        for (int j = 0; j < c_n; j++) if (mulmod(mem[j], ninv) != x_in[j]) nbad++;
        check("roundtrip_bad_words", nbad, 0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ntt_ctrl.md
# ntt_ctrl

Sequencer for one in-place NTT or inverse NTT over a coefficient memory of N = 2^LOGN words, driving a single-cycle butterfly unit. It generates the read, write and twiddle addresses and the butterfly mode selects. Coefficient and twiddle data flow directly from memory through the butterfly and back, so the controller carries no data. Mode 0 runs a forward Cooley-Tukey NTT; mode 1 runs an inverse Gentleman-Sande NTT.

## Interface
- LOGN, default 8, log2 of transform size; N = 2^LOGN, LOGN ≥ 2.
- AW, default LOGN, width of coefficient and twiddle addresses.
- clk_i  in  1  clock; all logic is on the rising edge.
- rstn_i  in  1  reset, synchronous and active-low.
- start_i  in  1  start request; sampled only when busy_o = 0.
- mode_i  in  1  0 selects forward CT, 1 selects inverse GS; latched on start.
- mul_sel_i  in  1  multiplier variant; latched on start.
- busy_o  out  1  high from the cycle after start acceptance through the last write.
- done_o  out  1  one-cycle pulse the cycle after the last write.
- stage_o  out  LOGN bits (clog2)  current stage index s.
- rd_en_o  out  1  coefficient and twiddle read strobe.
- rd_addr_a_o, rd_addr_b_o  out  AW  butterfly operand read addresses.
- tw_addr_o  out  AW  twiddle ROM address.
- wr_en_o  out  1  write-back strobe for the butterfly results.
- wr_addr_a_o, wr_addr_b_o  out  AW  write addresses.
- sel_butterfly_o  out  1  mode latched at start.
- sel_mul_o  out  1  mul_sel_i latched at start.

## Operation
- FSM states:
  - IDLE: waits for start_i; moves to RUN.
  - RUN: issues N/2 reads per stage; moves to GAP after the last read of a stage.
  - GAP: one bubble cycle; goes to RUN with s+1, or to FIN after stage LOGN-1.
  - FIN: asserts done_o; returns to IDLE.
- Per-stage butterfly counter i runs 0..N/2-1. Let l = log2(len) and blk = i >> l.
  - a = ((i >> l) << (l+1)) | (i & (len-1)); b = a + len.
- Forward (mode 0):
  - l = LOGN-1-s.
  - tw = 2^s + blk (indices 1..N-1, ascending).
- Inverse (mode 1):
  - l = s.
  - tw = 2^(LOGN-s) - 1 - blk.
- Memories have 1-cycle read latency. The butterfly is combinational, so results are written one cycle after the read.
  - wr_en_o and wr_addr_*_o are rd_en_o and rd_addr_*_o delayed by one register stage.
- The GAP cycle exists so the first read of stage s+1 never coincides with the final write of stage s. No read-after-write forwarding is required.
- start_i is ignored while busy_o = 1.
- mode_i and mul_sel_i are sampled only in the start cycle. sel_*_o hold constant for the whole transform and keep their value after done_o.
- rstn_i low at any edge, including mid-transform:
  - FSM returns to IDLE and all counters clear.
  - All outputs go to 0 on that edge.
  - No further rd_en_o or wr_en_o pulses occur; memory contents are left partial.
- All address arithmetic is modulo 2^AW; no intermediate exceeds N-1.

## Timing
- Reset value of every output is 0.
- Start accepted at edge 0. Stage s reads at cycles s·(N/2+1)+1 through s·(N/2+1)+N/2 and writes one cycle later.
- The last write is at cycle LOGN·(N/2+1). done_o pulses at cycle LOGN·(N/2+1)+1; busy_o drops on the same cycle.
- For LOGN = 8: last write at cycle 1032, done at 1033.
- Back-to-back operation: start_i high during the done_o cycle is accepted, and its first read follows on the next cycle.
- stage_o updates on the first read cycle of each stage.
- All outputs are registered with no combinational paths from the inputs.

## Test plan
- LOGN=3, mode 0, start at cycle 0 -> reads in order:
  - stage 0: (0,4),(1,5),(2,6),(3,7), tw 1,1,1,1.
  - stage 1: (0,2),(1,3),(4,6),(5,7), tw 2,2,3,3.
  - stage 2: (0,1),(2,3),(4,5),(6,7), tw 4,5,6,7.
  - done_o at cycle 16.
- LOGN=3, mode 1 -> reads in order:
  - stage 0: pairs (0,1),(2,3),(4,5),(6,7), tw 7,6,5,4.
  - stage 1: len 2, tw 3,3,2,2.
  - stage 2: len 4, tw 1,1,1,1.
  - sel_butterfly_o = 1 throughout.
- Write-back alignment: every wr_en_o cycle has wr_addr_*_o equal to the previous cycle's rd_addr_*_o.
  - rd_en_o is low on the GAP cycles, e.g. cycles 5 and 10 for LOGN=3.
  - No cycle has a read address equal to a same-cycle write address.
- start_i pulsed at cycle 7 while busy -> ignored, with no timing change.
  - start_i high at the done_o cycle 16 -> new run with first read at 17.
- rstn_i low at cycle 6 mid-stage-1 -> all outputs 0 from cycle 6.
  - No writes afterward; a new start after release runs the full 16-cycle sequence.
- LOGN=8, mode 0, with a golden software NTT model and a butterfly plus memory models -> memory matches the model.
  - done_o at cycle 1033.
  - Forward followed by inverse run (plus external N⁻¹ scaling in the model) returns the original input.
